bht_predictor: RTL and testbench

Parametrised dynamic next-PC predictor for the instruction-fetch stage, and the successor to the static PC predictor. Fetch supplies the current PC, instruction word, register operand and decoded immediate, and gets back a same-cycle next PC. Conditional branches are steered by a table of 2-bit saturating counters, trained by the commit stage through an update port. Optionally the table is indexed gshare-style with a committed global history.

---
 rtl/bht_predictor.sv | 111 +++++++++++
 tb/tb_bht_predictor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// bht_predictor: same-cycle next-PC predictor with a table of 2-bit saturating counters.
// Optional macro BHT_GHR_EN: gshare-style indexing with a committed global history.
`default_nettype none

module bht_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] now_pc,
  input  logic [31:0] now_inst,
  input  logic [31:0] val1,
  input  logic [31:0] imm,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  output logic [31:0] mispred_cnt
);

  localparam int         NENT    = 1 << IDX_W;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [1:0] CNT_MAX = 2'b11;
  localparam logic [1:0] CNT_MIN = 2'b00;

  logic [1:0]       cnt [NENT];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] uidx;
  logic             upd_en;
  logic [1:0]       ucnt;

  assign upd_en = rdy_in & upd_valid;

`ifdef BHT_GHR_EN
  logic [IDX_W-1:0] ghr;

  // Both indices use the history value from before this edge's shift.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ghr <= '0;
    end else if (upd_en) begin
      ghr <= {ghr[IDX_W-2:0], upd_taken};
    end
  end

  assign idx  = now_pc[IDX_W+1:2] ^ ghr;
  assign uidx = upd_pc[IDX_W+1:2] ^ ghr;
`else
  assign idx  = now_pc[IDX_W+1:2];
  assign uidx = upd_pc[IDX_W+1:2];
`endif

  always_comb begin
    next_pc    = now_pc + 32'd4;
    pred_taken = 1'b0;
    case (now_inst[6:0])
      OP_JAL: begin
        next_pc    = now_pc + imm;
        pred_taken = 1'b1;
      end
      OP_JALR: begin
        next_pc    = (val1 + imm) & ~32'h1;
        pred_taken = 1'b1;
      end
      OP_BR: begin
        if (cnt[idx][1]) begin
          next_pc    = now_pc + imm;
          pred_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ucnt = cnt[uidx];

  // Lookup is combinational off the table, so a same-cycle update is seen one cycle later.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NENT; i++) begin
        cnt[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      if (upd_taken) begin
        if (ucnt != CNT_MAX) cnt[uidx] <= ucnt + 2'd1;
      end else begin
        if (ucnt != CNT_MIN) cnt[uidx] <= ucnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mispred_cnt <= '0;
    end else if (upd_en && upd_mispred && (mispred_cnt != 32'hFFFF_FFFF)) begin
      mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{now_inst[31:7], upd_pc[31:IDX_W+2], upd_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: scoreboard bench for bht_predictor; expectations come from a
// spec-level reference model of the counter table, history and mispredict counter.
`default_nettype none

module tb_bht_predictor;

  localparam int         IDX_W    = 6;
  localparam logic [1:0] CNT_INIT = 2'b01;
  localparam int         NENT     = 1 << IDX_W;
  localparam logic [31:0] I_BR   = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;

  logic        clk_in, rst_in, rdy_in;
  logic [31:0] now_pc, now_inst, val1, imm;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [31:0] upd_pc;
  logic [31:0] mispred_cnt;

  bht_predictor #(.IDX_W(IDX_W), .CNT_INIT(CNT_INIT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .now_pc(now_pc), .now_inst(now_inst), .val1(val1), .imm(imm),
    .next_pc(next_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(mispred_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] npc;
    logic        pt;
    logic [31:0] mc;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc, inst, v1, im;
    logic        rdy, uv;
    logic [31:0] upc;
    logic        ut, um;
  } row_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model of the architectural state, advanced on the same edges as the DUT.
  logic [1:0]       m_cnt [NENT];
  logic [31:0]      m_mc;
  logic [IDX_W-1:0] m_ghr;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NENT; i++) m_cnt[i] = CNT_INIT;
      m_mc  = 32'd0;
      m_ghr = '0;
    end else if (rdy_in && upd_valid) begin
      logic [IDX_W-1:0] ui;
      ui = upd_pc[IDX_W+1:2];
`ifdef BHT_GHR_EN
      ui = ui ^ m_ghr;
      m_ghr = {m_ghr[IDX_W-2:0], upd_taken};
`endif
      if (upd_taken && m_cnt[ui] != 2'b11) m_cnt[ui] = m_cnt[ui] + 2'd1;
      if (!upd_taken && m_cnt[ui] != 2'b00) m_cnt[ui] = m_cnt[ui] - 2'd1;
      if (upd_mispred && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
    end
  end

  function automatic exp_t predict();
    exp_t             e;
    logic [IDX_W-1:0] li;
    li = now_pc[IDX_W+1:2];
`ifdef BHT_GHR_EN
    li = li ^ m_ghr;
`endif
    e.mc  = m_mc;
    e.npc = now_pc + 32'd4;
    e.pt  = 1'b0;
    if (now_inst[6:0] == 7'h6F) begin
      e.npc = now_pc + imm; e.pt = 1'b1;
    end else if (now_inst[6:0] == 7'h67) begin
      e.npc = (val1 + imm) & 32'hFFFF_FFFE; e.pt = 1'b1;
    end else if (now_inst[6:0] == 7'h63 && m_cnt[li] >= 2'b10) begin
      e.npc = now_pc + imm; e.pt = 1'b1;
    end
    return e;
  endfunction

  function automatic row_t mk(logic [31:0] pc, logic [31:0] inst, logic [31:0] v1,
                              logic [31:0] im, logic rdy, logic uv, logic [31:0] upc,
                              logic ut, logic um);
    row_t r;
    r.pc = pc; r.inst = inst; r.v1 = v1; r.im = im;
    r.rdy = rdy; r.uv = uv; r.upc = upc; r.ut = ut; r.um = um;
    return r;
  endfunction

  task automatic apply(row_t r);
    now_pc = r.pc; now_inst = r.inst; val1 = r.v1; imm = r.im;
    rdy_in = r.rdy; upd_valid = r.uv; upd_pc = r.upc;
    upd_taken = r.ut; upd_mispred = r.um;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    apply(mk(32'h100, I_BR, 0, 32'h40, 1, 0, 0, 0, 0));
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_in = 1'b1;
    // A training edge while reset is held must not touch the table or counter.
    apply(mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1));
    @(posedge clk_in); @(posedge clk_in); @(negedge clk_in);
    tests++; if (mispred_cnt !== 32'd0) begin fails++; $display("FAIL reset_mcnt got=%h want=0", mispred_cnt); end
    tests++; if (next_pc !== 32'h104 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL reset_br got=%h/%b want=00000104/0", next_pc, pred_taken); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    apply(mk(32'h100, I_BR, 0, 32'h40, 1, 0, 0, 0, 0));
    sb.push_back(exp_t'{32'h104, 1'b0, 32'd0});
    @(negedge clk_in);
    e = sb.pop_front();
    tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
      fails++; $display("FAIL reset_release got=%h/%b/%h want=%h/%b/%h", next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
  endtask

  task automatic test_decode();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 1, 0, 0, 0, 0),
             mk(32'h100, I_JAL, 0, 32'hFFFF_FFF0, 1, 0, 0, 0, 0),
             mk(32'h0, I_JALR, 32'h1001, 32'h2, 1, 0, 0, 0, 0),
             mk(32'h0, I_JALR, 32'h2000, 32'h7, 1, 0, 0, 0, 0),
             mk(32'hFFFF_FFFC, I_ADDI, 0, 32'h40, 1, 0, 0, 0, 0),
             mk(32'hFFFF_FFF0, I_JAL, 0, 32'h20, 1, 0, 0, 0, 0)};
    sb.push_back(exp_t'{32'h104, 1'b0, 32'd0});
    sb.push_back(exp_t'{32'hF0, 1'b1, 32'd0});
    sb.push_back(exp_t'{32'h1002, 1'b1, 32'd0});
    sb.push_back(exp_t'{32'h2006, 1'b1, 32'd0});
    sb.push_back(exp_t'{32'h0, 1'b0, 32'd0});
    sb.push_back(exp_t'{32'h10, 1'b1, 32'd0});
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL decode[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
  endtask

  task automatic test_train();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0)};
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      sb.push_back(predict());
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL train[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
  endtask

  task automatic test_same_cycle_alias();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h200, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h200, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h200, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h200, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h200, 0, 0),
             mk(32'h104, I_BR, 0, 32'h40, 1, 0, 32'h200, 0, 0)};
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      sb.push_back(predict());
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL same_alias[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
  endtask

  task automatic test_rdy_low();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 0, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 0, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 0, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 1, 1)};
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      sb.push_back(predict());
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL rdy_low[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
    tests++; if (mispred_cnt !== 32'd0 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL rdy_low_state got=%h/%b want=00000000/0", mispred_cnt, pred_taken); end
  endtask

  task automatic test_back_to_back_mispred();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 1, 1),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 1)};
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      sb.push_back(predict());
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL mispred[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
    tests++; if (mispred_cnt !== 32'd5) begin
      fails++; $display("FAIL mispred_five got=%h want=00000005", mispred_cnt); end
    // Asynchronous reset in the middle of the low phase clears state before any edge.
    #2 rst_in = 1'b1;
    #1;
    tests++; if (mispred_cnt !== 32'd0) begin
      fails++; $display("FAIL async_rst_mcnt got=%h want=00000000", mispred_cnt); end
    tests++; if (next_pc !== 32'h104 || pred_taken !== 1'b0) begin
      fails++; $display("FAIL async_rst_table got=%h/%b want=00000104/0", next_pc, pred_taken); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

`ifdef BHT_GHR_EN
  task automatic test_ghr();
    row_t rows[$];
    exp_t e;
    do_reset();
    rows = '{mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 1, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 1, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0),
             mk(32'h118, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0),
             mk(32'h100, I_BR, 0, 32'h40, 1, 0, 32'h100, 0, 0)};
    foreach (rows[k]) begin
      @(posedge clk_in); #1;
      apply(rows[k]);
      sb.push_back(predict());
      @(negedge clk_in);
      e = sb.pop_front();
      tests++; if (next_pc !== e.npc || pred_taken !== e.pt || mispred_cnt !== e.mc) begin
        fails++; $display("FAIL ghr[%0d] got=%h/%b/%h want=%h/%b/%h", k, next_pc, pred_taken, mispred_cnt, e.npc, e.pt, e.mc); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_train();
    test_same_cycle_alias();
    test_rdy_low();
    test_back_to_back_mispred();
`ifdef BHT_GHR_EN
    test_ghr();
`endif
    tests++; if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
